// File: rtl/pulse_burst_gen_pkg.sv
// Shared constants and helpers for the pulse burst generator.
// Holds default timing parameters, FSM state encodings and the counter width helper.
package pulse_burst_gen_pkg;

    localparam int DEF_PERIOD    = 3;
    localparam int DEF_HIGH_CYC  = 2;
    localparam int DEF_BURST_NUM = 3;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gen_cnt.sv
// Generic add/end counter: counts 0..MAX-1 on add, wraps to 0, with synchronous clear.
// end_cnt flags the cycle in which the terminal value is reached while adding.
module gen_cnt
    import pulse_burst_gen_pkg::*;
#(
    parameter int MAX = 3,
    parameter int W   = clog2_min1(MAX)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         add,
    output logic [W-1:0] cnt,
    output logic         end_cnt
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign end_cnt = add && (cnt_q == LAST);
    assign cnt     = cnt_q;

    // NOTE: default assignment first so every path drives cnt_d and no latch is inferred.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (end_cnt) begin
            cnt_d = '0;
        end else if (add) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pulse_burst_gen.sv
// Burst generator: on en, emits BURST_NUM pulses of HIGH_CYC high cycles every PERIOD cycles.
// stop aborts immediately; done pulses once after a burst finishes normally.
module pulse_burst_gen
    import pulse_burst_gen_pkg::*;
#(
    parameter int PERIOD    = DEF_PERIOD,
    parameter int HIGH_CYC  = DEF_HIGH_CYC,
    parameter int BURST_NUM = DEF_BURST_NUM,
    parameter int RETRIG    = 0,
    parameter int IDX_W     = clog2_min1(BURST_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             stop,
    output logic             dout,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] pulse_idx
);

    localparam int CNT0_W = clog2_min1(PERIOD);
    localparam logic [CNT0_W-1:0] HIGH_LIM = CNT0_W'(HIGH_CYC);

    if (PERIOD < 2) begin : g_bad_period
        $fatal(1, "pulse_burst_gen: PERIOD must be >= 2");
    end
    if (HIGH_CYC < 1 || HIGH_CYC >= PERIOD) begin : g_bad_high
        $fatal(1, "pulse_burst_gen: HIGH_CYC must satisfy 1 <= HIGH_CYC < PERIOD");
    end
    if (BURST_NUM < 1) begin : g_bad_burst
        $fatal(1, "pulse_burst_gen: BURST_NUM must be >= 1");
    end

    logic [0:0]        state_q, state_d;
    logic              dout_q, dout_d;
    logic              done_q, done_d;
    logic [CNT0_W-1:0] cnt0;
    logic [IDX_W-1:0]  cnt1;
    logic              end_cnt0;
    logic              end_cnt1;
    logic              restart;
    logic              cnt_clr;

    assign busy    = (state_q == ST_RUN);
    assign restart = busy && en && (RETRIG != 0);
    assign cnt_clr = stop || restart;

    gen_cnt #(.MAX(PERIOD), .W(CNT0_W)) u_cnt0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .add     (busy),
        .cnt     (cnt0),
        .end_cnt (end_cnt0)
    );

    gen_cnt #(.MAX(BURST_NUM), .W(IDX_W)) u_cnt1 (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (cnt_clr),
        .add     (end_cnt0),
        .cnt     (cnt1),
        .end_cnt (end_cnt1)
    );

    // en on the final cycle of a burst chains straight into the next one.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (en && !stop) state_d = ST_RUN;
            ST_RUN:  if (stop || (end_cnt1 && !en)) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dout_d = busy && !stop && (cnt0 < HIGH_LIM);
        done_d = end_cnt1 && !stop;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dout_q  <= dout_d;
            done_q  <= done_d;
        end
    end

    assign dout      = dout_q;
    assign done      = done_q;
    assign pulse_idx = cnt1;

endmodule

// File: tb/tb_pulse_burst_gen.sv
// Directed bench for pulse_burst_gen: per-cycle expected waveforms written as bit masks
// (bit c = expected value in cycle c, cycle 0 being the cycle en is first driven).
module tb_pulse_burst_gen;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       stop = 1'b0;
    logic       dout0, busy0, done0;
    logic       dout1, busy1, done1;
    logic [1:0] idx0, idx1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pulse_burst_gen #(.RETRIG(0)) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .stop      (stop),
        .dout      (dout0),
        .busy      (busy0),
        .done      (done0),
        .pulse_idx (idx0)
    );

    pulse_burst_gen #(.RETRIG(1)) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .stop      (stop),
        .dout      (dout1),
        .busy      (busy1),
        .done      (done1),
        .pulse_idx (idx1)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic scenario(input string name, input bit rt,
                            input logic [23:0] en_m, input logic [23:0] stop_m,
                            input logic [23:0] dout_m, input logic [23:0] busy_m,
                            input logic [23:0] done_m,
                            input logic [23:0] idx_b0, input logic [23:0] idx_b1);
        logic       d, b, dn;
        logic [1:0] ix;
        for (int c = 0; c < 24; c++) begin
            en   = en_m[c];
            stop = stop_m[c];
            d  = rt ? dout1 : dout0;
            b  = rt ? busy1 : busy0;
            dn = rt ? done1 : done0;
            ix = rt ? idx1  : idx0;
            check($sformatf("%s dout c%0d", name, c), {7'd0, d},  {7'd0, dout_m[c]});
            check($sformatf("%s busy c%0d", name, c), {7'd0, b},  {7'd0, busy_m[c]});
            check($sformatf("%s done c%0d", name, c), {7'd0, dn}, {7'd0, done_m[c]});
            check($sformatf("%s idx c%0d", name, c),  {6'd0, ix}, {6'd0, idx_b1[c], idx_b0[c]});
            tick();
        end
        en   = 1'b0;
        stop = 1'b0;
    endtask

    initial begin
        #2;
        check("reset dout0", {7'd0, dout0}, 8'd0);
        check("reset busy0", {7'd0, busy0}, 8'd0);
        check("reset done0", {7'd0, done0}, 8'd0);
        check("reset idx0",  {6'd0, idx0},  8'd0);
        check("reset busy1", {7'd0, busy1}, 8'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single burst.
        scenario("single", 1'b0, 24'h1, 24'h0, 24'h36C, 24'h3FE, 24'h400, 24'h70, 24'h380);
        // Abort with stop at cycle 5.
        scenario("stop", 1'b0, 24'h1, 24'h20, 24'h2C, 24'h3E, 24'h0, 24'h30, 24'h0);
        // Simultaneous en and stop in IDLE: stop wins.
        scenario("en_stop", 1'b0, 24'h1, 24'h1, 24'h0, 24'h0, 24'h0, 24'h0, 24'h0);
        // Second en while busy is ignored without retrigger.
        scenario("ignore", 1'b0, 24'h11, 24'h0, 24'h36C, 24'h3FE, 24'h400, 24'h70, 24'h380);
        // Retrigger at cycle 4 restarts the burst.
        scenario("retrig", 1'b1, 24'h11, 24'h0, 24'h36EC, 24'h3FFE, 24'h4000, 24'h710, 24'h3800);
        // en on the final cycle chains a back-to-back burst.
        scenario("b2b", 1'b0, 24'h201, 24'h0, 24'h6DB6C, 24'h7FFFE, 24'h80400, 24'hE070, 24'h70380);

        // Asynchronous reset mid-burst.
        en = 1'b1;
        tick();
        en = 1'b0;
        tick();
        tick();
        tick();
        check("pre-reset busy0", {7'd0, busy0}, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async busy0", {7'd0, busy0}, 8'd0);
        check("async dout0", {7'd0, dout0}, 8'd0);
        check("async done0", {7'd0, done0}, 8'd0);
        check("async idx0",  {6'd0, idx0},  8'd0);
        check("async busy1", {7'd0, busy1}, 8'd0);
        tick();
        check("held done0", {7'd0, done0}, 8'd0);
        rst_n = 1'b1;
        tick();
        check("post busy0", {7'd0, busy0}, 8'd0);
        scenario("after_rst", 1'b0, 24'h1, 24'h0, 24'h36C, 24'h3FE, 24'h400, 24'h70, 24'h380);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
